attack_controller: RTL and testbench



---
 rtl/fight_pkg.sv | 25 ++
 rtl/frame_timer.sv | 33 +++
 rtl/attack_controller.sv | 149 ++++++++++++++
 tb/tb_attack_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared fight definitions: attack phase encoding and default frame timings.
// Imported by attack_controller and, later, by the health bar logic.
package fight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WINDUP   = 3'd1,
    ST_STRIKE   = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_COOLDOWN = 3'd4
  } attack_state_t;

  localparam int unsigned X_W_DEF             = 10;
  localparam int unsigned REACH_DEF           = 64;
  localparam int unsigned WINDUP_FRAMES_DEF   = 4;
  localparam int unsigned STRIKE_FRAMES_DEF   = 3;
  localparam int unsigned RECOVER_FRAMES_DEF  = 6;
  localparam int unsigned COOLDOWN_FRAMES_DEF = 8;

  // Larger of two frame counts, used to size the shared phase counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter for one timed phase: counts frame ticks while enabled and
// pulses o_done_c on the tick that reaches i_target, clearing itself then.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clear        : force counter to 0 (phase entry / abort)
//   i_en           : current phase is timed
//   i_tick         : one-cycle frame pulse
//   i_target       : frame count that ends the phase
//   o_done_c       : combinational done pulse (same cycle as the final tick)
module frame_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_tick,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_done_c = i_en && i_tick && ((r_cnt + CNT_W'(1)) == i_target);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && i_tick) begin
      r_cnt <= o_done_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/attack_controller.sv
// Per-fighter attack sequencer: key press -> windup -> strike -> recover ->
// cooldown, resolving range and guard at the end of windup and driving the
// hit/block level pair to the opponent's health bar.
//   Clk, Reset        : clock, synchronous active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   attack_key        : key level; an attack starts on its rising edge
//   attacker_x        : this fighter's x position
//   defender_x        : opponent's x position
//   defender_blocking : opponent holding guard
//   game_over         : either fighter dead; aborts and holds Idle
//   hit, block        : registered strike result, held through Strike
//   attacking         : Windup/Strike/Recover decode
//   phase             : current state encoding
module attack_controller
  import fight_pkg::*;
#(
  parameter int unsigned X_W             = X_W_DEF,
  parameter int unsigned REACH           = REACH_DEF,
  parameter int unsigned WINDUP_FRAMES   = WINDUP_FRAMES_DEF,
  parameter int unsigned STRIKE_FRAMES   = STRIKE_FRAMES_DEF,
  parameter int unsigned RECOVER_FRAMES  = RECOVER_FRAMES_DEF,
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_tick,
  input  logic           attack_key,
  input  logic [X_W-1:0] attacker_x,
  input  logic [X_W-1:0] defender_x,
  input  logic           defender_blocking,
  input  logic           game_over,
  output logic           hit,
  output logic           block,
  output logic           attacking,
  output logic [2:0]     phase
);

  localparam int unsigned MAX_FRAMES =
    max2(max2(WINDUP_FRAMES, STRIKE_FRAMES), max2(RECOVER_FRAMES, COOLDOWN_FRAMES));
  localparam int unsigned CNT_W = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0] WINDUP_T   = CNT_W'(WINDUP_FRAMES);
  localparam logic [CNT_W-1:0] STRIKE_T   = CNT_W'(STRIKE_FRAMES);
  localparam logic [CNT_W-1:0] RECOVER_T  = CNT_W'(RECOVER_FRAMES);
  localparam logic [CNT_W-1:0] COOLDOWN_T = CNT_W'(COOLDOWN_FRAMES);

  attack_state_t    r_state;
  logic             r_key_q;
  logic             r_hit;
  logic             r_block;

  logic             w_key_rise;
  logic [X_W-1:0]   w_dist;
  logic             w_connect;
  logic [CNT_W-1:0] w_target;
  logic             w_timed;
  logic             w_timer_clr;
  logic             w_done;

  assign w_key_rise = attack_key & ~r_key_q;

  // Larger minus smaller, so the unsigned distance never wraps.
  assign w_dist    = (attacker_x >= defender_x) ? (attacker_x - defender_x)
                                                : (defender_x - attacker_x);
  assign w_connect = (w_dist <= X_W'(REACH));

  // Phase length for the shared timer.
  always_comb begin
    w_target = '0;
    case (r_state)
      ST_WINDUP:   w_target = WINDUP_T;
      ST_STRIKE:   w_target = STRIKE_T;
      ST_RECOVER:  w_target = RECOVER_T;
      ST_COOLDOWN: w_target = COOLDOWN_T;
      default:     w_target = '0;
    endcase
  end

  // Idle never counts, so a tick on the Idle->Windup cycle is not seen.
  assign w_timed     = (r_state != ST_IDLE);
  assign w_timer_clr = game_over || (r_state == ST_IDLE);

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_clear  (w_timer_clr),
    .i_en     (w_timed),
    .i_tick   (frame_tick),
    .i_target (w_target),
    .o_done_c (w_done)
  );

  // Sequencer; strike result is latched on the Windup exit edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_key_q <= 1'b1;
      r_hit   <= 1'b0;
      r_block <= 1'b0;
    end else begin
      r_key_q <= attack_key;
      if (game_over) begin
        r_state <= ST_IDLE;
        r_hit   <= 1'b0;
        r_block <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_key_rise) r_state <= ST_WINDUP;
          end
          ST_WINDUP: begin
            if (w_done) begin
              r_state <= ST_STRIKE;
              r_hit   <= w_connect & ~defender_blocking;
              r_block <= w_connect &  defender_blocking;
            end
          end
          ST_STRIKE: begin
            if (w_done) begin
              r_state <= ST_RECOVER;
              r_hit   <= 1'b0;
              r_block <= 1'b0;
            end
          end
          ST_RECOVER: begin
            if (w_done) r_state <= ST_COOLDOWN;
          end
          ST_COOLDOWN: begin
            if (w_done) r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_hit   <= 1'b0;
            r_block <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hit       = r_hit;
  assign block     = r_block;
  assign phase     = r_state;
  assign attacking = (r_state == ST_WINDUP) || (r_state == ST_STRIKE) ||
                     (r_state == ST_RECOVER);

endmodule

// File: tb/tb_attack_controller.sv
// Directed bench for attack_controller with an expected-value queue.
module tb_attack_controller;
  import fight_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       attack_key = 1'b0;
  logic [9:0] attacker_x = 10'd100;
  logic [9:0] defender_x = 10'd150;
  logic       defender_blocking = 1'b0;
  logic       game_over = 1'b0;
  logic       hit, block, attacking;
  logic [2:0] phase;

  int n_checks = 0;
  int n_err    = 0;
  logic [5:0] sb[$];

  attack_controller dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .frame_tick        (frame_tick),
    .attack_key        (attack_key),
    .attacker_x        (attacker_x),
    .defender_x        (defender_x),
    .defender_blocking (defender_blocking),
    .game_over         (game_over),
    .hit               (hit),
    .block             (block),
    .attacking         (attacking),
    .phase             (phase)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One idle clock, then a single-cycle frame tick.
  task automatic ftick();
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Expected {hit, block, attacking, phase}; attacking derived from phase.
  task automatic push(input logic h, input logic b, input attack_state_t st);
    logic a;
    a = (st == ST_WINDUP) || (st == ST_STRIKE) || (st == ST_RECOVER);
    sb.push_back({h, b, a, 3'(st)});
  endtask

  task automatic chk(input string tag);
    logic [5:0] obs;
    logic [5:0] e;
    obs = {hit, block, attacking, phase};
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed=%b expected=<empty queue>", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed {hit,block,atk,phase}=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  task automatic expect_now(input logic h, input logic b, input attack_state_t st,
                            input string tag);
    push(h, b, st);
    chk(tag);
  endtask

  // Full attack from Idle with key already released; key is left held.
  task automatic attack(input logic eh, input logic eb, input string tag,
                        input bit tick_on_press, input bit repress);
    logic blk_save;
    blk_save   = defender_blocking;
    attack_key = 1'b1;
    frame_tick = tick_on_press;
    step();
    frame_tick = 1'b0;
    expect_now(1'b0, 1'b0, ST_WINDUP, {tag, "/press"});
    for (int i = 1; i <= 4; i++) begin
      ftick();
      if (i < 4) expect_now(1'b0, 1'b0, ST_WINDUP, $sformatf("%s/windup%0d", tag, i));
      else       expect_now(eh, eb, ST_STRIKE, $sformatf("%s/windup%0d", tag, i));
    end
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) defender_blocking = ~defender_blocking;
      ftick();
      if (i < 3) expect_now(eh, eb, ST_STRIKE, $sformatf("%s/strike%0d", tag, i));
      else       expect_now(1'b0, 1'b0, ST_RECOVER, $sformatf("%s/strike%0d", tag, i));
    end
    defender_blocking = blk_save;
    for (int i = 1; i <= 6; i++) begin
      if (repress && i == 3) begin
        attack_key = 1'b0;
        step();
        attack_key = 1'b1;
      end
      ftick();
      if (i < 6) expect_now(1'b0, 1'b0, ST_RECOVER, $sformatf("%s/recover%0d", tag, i));
      else       expect_now(1'b0, 1'b0, ST_COOLDOWN, $sformatf("%s/recover%0d", tag, i));
    end
    for (int i = 1; i <= 8; i++) begin
      ftick();
      if (i < 8) expect_now(1'b0, 1'b0, ST_COOLDOWN, $sformatf("%s/cool%0d", tag, i));
      else       expect_now(1'b0, 1'b0, ST_IDLE, $sformatf("%s/cool%0d", tag, i));
    end
  endtask

  task automatic release_key();
    attack_key = 1'b0;
    step();
    step();
  endtask

  initial begin
    // Reset
    step();
    step();
    Reset = 1'b0;
    step();
    expect_now(1'b0, 1'b0, ST_IDLE, "reset");

    // Unguarded hit at distance 50
    attack(1'b1, 1'b0, "hit50", 1'b0, 1'b0);
    release_key();

    // Guarded strike; guard toggles mid-strike without effect
    defender_blocking = 1'b1;
    attack(1'b0, 1'b1, "block50", 1'b0, 1'b0);
    defender_blocking = 1'b0;
    release_key();

    // Out of reach (100): miss, full timing
    attacker_x = 10'd300; defender_x = 10'd200;
    attack(1'b0, 1'b0, "miss100", 1'b0, 1'b0);
    release_key();

    // Exactly at reach, attacker on the right
    attacker_x = 10'd200; defender_x = 10'd136;
    attack(1'b1, 1'b0, "reach64", 1'b0, 1'b0);
    release_key();

    // One past reach, defender on the right
    attacker_x = 10'd100; defender_x = 10'd165;
    attack(1'b0, 1'b0, "reach65", 1'b0, 1'b0);
    release_key();

    // Tick on the press cycle is not counted; second press during Recover ignored
    attacker_x = 10'd100; defender_x = 10'd164;
    attack(1'b1, 1'b0, "tickpress_repress", 1'b1, 1'b1);
    // Key still held: no auto-repeat
    for (int i = 0; i < 3; i++) ftick();
    expect_now(1'b0, 1'b0, ST_IDLE, "held_no_repeat");
    release_key();
    // Fresh press starts a second attack
    attack(1'b1, 1'b0, "second", 1'b0, 1'b0);
    release_key();

    // game_over mid-Strike
    attack_key = 1'b1;
    step();
    expect_now(1'b0, 1'b0, ST_WINDUP, "go/press");
    for (int i = 0; i < 5; i++) ftick();
    expect_now(1'b1, 1'b0, ST_STRIKE, "go/strike");
    game_over = 1'b1;
    step();
    expect_now(1'b0, 1'b0, ST_IDLE, "go/abort");
    attack_key = 1'b0;
    step();
    attack_key = 1'b1;
    step();
    ftick();
    expect_now(1'b0, 1'b0, ST_IDLE, "go/press_ignored");
    game_over = 1'b0;
    step();
    ftick();
    expect_now(1'b0, 1'b0, ST_IDLE, "go/held_after_release");
    release_key();

    // Simultaneous key rise and game_over in Idle
    attack_key = 1'b1;
    game_over  = 1'b1;
    step();
    expect_now(1'b0, 1'b0, ST_IDLE, "go_vs_rise");
    game_over = 1'b0;
    step();
    step();
    expect_now(1'b0, 1'b0, ST_IDLE, "go_vs_rise/after");
    release_key();

    // Reset during Windup with key held
    attack_key = 1'b1;
    step();
    expect_now(1'b0, 1'b0, ST_WINDUP, "rst/press");
    ftick();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    expect_now(1'b0, 1'b0, ST_IDLE, "rst/idle");
    for (int i = 0; i < 5; i++) ftick();
    expect_now(1'b0, 1'b0, ST_IDLE, "rst/held_no_attack");
    release_key();
    attack(1'b1, 1'b0, "rst/repress", 1'b0, 1'b0);
    release_key();

    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $error("FAIL sb_drain: observed=%0d leftover expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
